// File: rtl/aes_key_sched_seq_if.sv
// Key-load handshake and round-key read port of aes_key_sched_seq.
// rd_inv exists only when AES_KEY_SCHED_EQINV_EN is defined.
interface aes_key_sched_seq_if #(
  parameter int NK_MAX = 8,
  parameter int IDX_W  = $clog2(NK_MAX + 7)
);
  // Handshake: a key transfers on a cycle where key_valid && key_ready are both high.
  // The offer is a single-cycle look; the master may drop key_valid at any time.
  // A read request is rd_en for one cycle, and its response is rd_vld on the next cycle.
  logic                  key_valid;
  logic                  key_ready;
  logic [1:0]            key_len;
  logic [32*NK_MAX-1:0]  key;
  logic                  key_err;
  logic                  busy;
  logic                  done;
  logic [3:0]            nr;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_vld;
  logic                  rd_avail;
  logic [127:0]          rd_data;
  logic [1:0]            state_dbg;
`ifdef AES_KEY_SCHED_EQINV_EN
  logic                  rd_inv;
`endif

  modport master (
`ifdef AES_KEY_SCHED_EQINV_EN
    output rd_inv,
`endif
    output key_valid, key_len, key, rd_en, rd_idx,
    input  key_ready, key_err, busy, done, nr, rd_vld, rd_avail, rd_data, state_dbg
  );

  modport slave (
`ifdef AES_KEY_SCHED_EQINV_EN
    input  rd_inv,
`endif
    input  key_valid, key_len, key, rd_en, rd_idx,
    output key_ready, key_err, busy, done, nr, rd_vld, rd_avail, rd_data, state_dbg
  );
endinterface

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/192/256 key schedule: one expanded word per cycle through a shared SubWord,
// round keys kept in a flop store behind a 1-cycle read port. Optional macro: AES_KEY_SCHED_EQINV_EN.
module aes_key_sched_seq #(
  parameter int NK_MAX = 8
) (
  input logic                clk,
  input logic                rst_n,
  aes_key_sched_seq_if.slave bus
);
  localparam int NR_MAX  = NK_MAX + 6;
  localparam int N_WORDS = 4 * (NK_MAX + 7);
  localparam int CNT_W   = $clog2(N_WORDS + 1);
  localparam int IDX_W   = $clog2(NR_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      store [N_WORDS];
  logic [CNT_W-1:0] i_q;
  logic [2:0]       mod_q;
  logic [7:0]       rcon_q;
  logic [3:0]       nk_q;
  logic [3:0]       nr_q;
  logic             key_err_q;
  logic             rd_vld_q;
  logic             rd_avail_q;
  logic [127:0]     rd_data_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as the GF(2^8) inverse (x^254 by an addition chain) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    v    = gf_mul(x252, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

`ifdef AES_KEY_SCHED_EQINV_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
  endfunction
`endif

  // Key-length decode and acceptance
  logic       key_ready_c;
  logic [3:0] nk_new;
  logic       len_legal;
  logic       offer;
  logic       accept;

  always_comb begin
    nk_new = 4'd0;
    case (bus.key_len)
      2'd0:    nk_new = 4'd4;
      2'd1:    nk_new = 4'd6;
      2'd2:    nk_new = 4'd8;
      default: nk_new = 4'd0;
    endcase
  end

  assign key_ready_c = (state_q != S_EXPAND);
  assign len_legal   = (bus.key_len != 2'd3) && (nk_new <= 4'(NK_MAX));
  assign offer       = bus.key_valid && key_ready_c;
  assign accept      = offer && len_legal;

  logic [CNT_W-1:0] last_idx;
  assign last_idx = CNT_W'({nr_q, 2'b11});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_EXPAND;
      S_EXPAND: if (i_q == last_idx) state_d = S_DONE;
      S_DONE:   if (accept) state_d = S_EXPAND;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next-word datapath: one SubWord shared by the i%Nk==0 and the Nk==8, i%Nk==4 cases
  logic [31:0] w_prev, w_back, sub_in, sub_out, new_w;
  logic        mod_wrap;

  always_comb begin
    w_prev = 32'h0;
    w_back = 32'h0;
    if (state_q == S_EXPAND) begin
      w_prev = store[i_q - CNT_W'(1)];
      w_back = store[i_q - CNT_W'(nk_q)];
    end
    sub_in  = (mod_q == 3'd0) ? {w_prev[7:0], w_prev[31:8]} : w_prev;
    sub_out = sub_word(sub_in);
    if (mod_q == 3'd0)
      new_w = w_back ^ sub_out ^ {24'h0, rcon_q};
    else if (nk_q == 4'd8 && mod_q == 3'd4)
      new_w = w_back ^ sub_out;
    else
      new_w = w_back ^ w_prev;
  end

  assign mod_wrap = ({1'b0, mod_q} == (nk_q - 4'd1));

  // Read port: a round is available once its top word index is below the write counter
  logic [7:0]       rd_last8;
  logic             rd_hit;
  logic [CNT_W-1:0] rd_base;
  logic [127:0]     rd_word;

  assign rd_last8 = 8'({bus.rd_idx, 2'b11});
  assign rd_hit   = (8'(bus.rd_idx) <= 8'(nr_q)) && (rd_last8 < 8'(i_q));
  assign rd_base  = CNT_W'({bus.rd_idx, 2'b00});

  always_comb begin
    rd_word = 128'h0;
    if (rd_hit) begin
      rd_word = {store[rd_base + CNT_W'(3)], store[rd_base + CNT_W'(2)],
                 store[rd_base + CNT_W'(1)], store[rd_base]};
`ifdef AES_KEY_SCHED_EQINV_EN
      if (bus.rd_inv && (bus.rd_idx != '0) && (8'(bus.rd_idx) != 8'(nr_q))) begin
        for (int c = 0; c < 4; c++) rd_word[32*c +: 32] = inv_mix_col(rd_word[32*c +: 32]);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_WORDS; k++) store[k] <= 32'h0;
      i_q        <= '0;
      mod_q      <= 3'd0;
      rcon_q     <= 8'h00;
      nk_q       <= 4'd0;
      nr_q       <= 4'd0;
      key_err_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_avail_q <= 1'b0;
      rd_data_q  <= 128'h0;
    end else begin
      key_err_q <= offer && !len_legal;
      if (accept) begin
        for (int k = 0; k < NK_MAX; k++) begin
          if (k < int'(nk_new)) store[k] <= bus.key[32*k +: 32];
        end
        i_q    <= CNT_W'(nk_new);
        mod_q  <= 3'd0;
        rcon_q <= 8'h01;
        nk_q   <= nk_new;
        nr_q   <= nk_new + 4'd6;
      end else if (state_q == S_EXPAND) begin
        store[i_q] <= new_w;
        i_q        <= i_q + CNT_W'(1);
        mod_q      <= mod_wrap ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
      rd_vld_q   <= bus.rd_en;
      rd_avail_q <= bus.rd_en && rd_hit;
      rd_data_q  <= bus.rd_en ? rd_word : 128'h0;
    end
  end

  assign bus.key_ready = key_ready_c;
  assign bus.key_err   = key_err_q;
  assign bus.busy      = (state_q == S_EXPAND);
  assign bus.done      = (state_q == S_DONE);
  assign bus.nr        = nr_q;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_avail  = rd_avail_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.state_dbg = state_q;

  // IDX_W documents the read index range the store layout relies on.
  logic unused_ok;
  assign unused_ok = (IDX_W > 0);
endmodule
